// File: rtl/lcd_frame_refresher_if.sv
// Host-side bundle for lcd_frame_refresher.
// Carries the refresh controls, the synchronous character-memory read port,
// the status flags and the HD44780 pin bus.
//   master : the refresher itself (drives mem_addr, status and LCD pins)
//   slave  : the host / memory / panel side
// AW is the character-memory address width; it must match the refresher's AW.
interface lcd_frame_refresher_if #(
  parameter int AW = 5
);
  logic          refresh_req;
  logic          auto_refresh;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          busy;
  logic          frame_done;
  logic [7:0]    LCD_DATA;
  logic          LCD_RS;
  logic          LCD_RW;
  logic          LCD_EN;
  logic          LCD_ON;

  modport master (
    input  refresh_req, auto_refresh, mem_data,
    output mem_addr, busy, frame_done,
    output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON
  );

  modport slave (
    output refresh_req, auto_refresh, mem_data,
    input  mem_addr, busy, frame_done,
    input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON
  );
endinterface

// File: rtl/lcd_frame_refresher.sv
// HD44780 character-LCD sequencer.
// After reset: power-up wait, then the four init commands. Afterwards it
// repaints the whole panel from a synchronous character memory on request
// (refresh_req) or continuously (auto_refresh), generating RS/EN/DATA timing.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active low
//   bus  : lcd_frame_refresher_if.master -- refresh controls, memory read port
//          (mem_addr out, mem_data in one cycle later), busy / frame_done,
//          LCD_DATA / LCD_RS / LCD_RW / LCD_EN / LCD_ON.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PWR_WAIT  | post-reset settling wait, panel power on
// INIT      | load cycle of the next init command byte
// IDLE      | waiting for a request, auto mode or pending request
// ROW_CMD   | load cycle of the row's set-DDRAM command
// FETCH     | mem_addr presented, memory read in flight
// XFER      | byte sub-sequence: LOAD / SETUP / PULSE / WAIT phases
// FRAME_END | frame_done pulse; chain into next frame or return to IDLE
module lcd_frame_refresher #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int SETUP_CYCLES = 4,
  parameter int EN_CYCLES    = 16,
  parameter int CMD_DELAY    = 262143,
  parameter int CLR_DELAY    = 262143,
  parameter int PWR_DELAY    = 262143,
  parameter int AW           = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input logic                  clk,
  input logic                  rst,
  lcd_frame_refresher_if.master bus
);

  // One counter times every phase, so it is sized for the longest of them.
  localparam int MAX_D0 = (PWR_DELAY > CMD_DELAY) ? PWR_DELAY : CMD_DELAY;
  localparam int MAX_D  = (MAX_D0 > CLR_DELAY) ? MAX_D0 : CLR_DELAY;
  localparam int MAX_P  = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_T  = (MAX_D > MAX_P) ? MAX_D : MAX_P;
  localparam int CW     = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] PWR_TC   = CW'(PWR_DELAY - 1);
  localparam logic [CW-1:0] CMD_TC   = CW'(CMD_DELAY - 1);
  localparam logic [CW-1:0] CLR_TC   = CW'(CLR_DELAY - 1);
  localparam logic [CW-1:0] SETUP_TC = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_TC    = CW'(EN_CYCLES - 1);
  localparam logic [5:0]    LAST_COL = 6'(COLS - 1);
  localparam logic [1:0]    LAST_ROW = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, ROW_CMD, FETCH, XFER, FRAME_END
  } state_t;

  typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic [1:0]    row;
  logic [5:0]    col;
  logic [AW-1:0] next_addr;
  logic          pending;
  logic          in_init;
  logic          is_clear;

  logic start_frame;
  logic wait_done;

  assign start_frame = bus.refresh_req | bus.auto_refresh | pending;
  assign wait_done   = (cnt == (is_clear ? CLR_TC : CMD_TC));

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = (ROWS > 1) ? 8'h38 : 8'h30;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] r);
    logic [7:0] b;
    case (r)
      2'd0:    b = 8'h00;
      2'd1:    b = 8'h40;
      2'd2:    b = 8'h14;
      default: b = 8'h54;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= PWR_WAIT;
      phase          <= PH_LOAD;
      cnt            <= '0;
      init_idx       <= '0;
      row            <= '0;
      col            <= '0;
      next_addr      <= '0;
      pending        <= 1'b0;
      in_init        <= 1'b0;
      is_clear       <= 1'b0;
      bus.mem_addr   <= '0;
      bus.busy       <= 1'b1;
      bus.frame_done <= 1'b0;
      bus.LCD_DATA   <= 8'h00;
      bus.LCD_RS     <= 1'b0;
      bus.LCD_RW     <= 1'b0;
      bus.LCD_EN     <= 1'b0;
      bus.LCD_ON     <= 1'b0;
    end else begin
      bus.LCD_RW <= 1'b0;
      // Requests arriving while busy collapse into one pending frame; states
      // that consume a request clear this below (later assignment wins).
      if (bus.refresh_req && bus.busy) pending <= 1'b1;

      case (state)
        PWR_WAIT: begin
          bus.LCD_ON <= 1'b1;
          if (cnt == PWR_TC) begin
            cnt      <= '0;
            init_idx <= '0;
            state    <= INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        INIT: begin
          bus.LCD_DATA <= init_byte(init_idx);
          bus.LCD_RS   <= 1'b0;
          in_init      <= 1'b1;
          is_clear     <= (init_idx == 2'd2);
          cnt          <= '0;
          phase        <= PH_SETUP;
          state        <= XFER;
        end

        IDLE: begin
          if (start_frame) begin
            pending  <= 1'b0;
            bus.busy <= 1'b1;
            row      <= '0;
            col      <= '0;
            state    <= ROW_CMD;
          end
        end

        ROW_CMD: begin
          bus.LCD_DATA <= 8'h80 | row_base(row);
          bus.LCD_RS   <= 1'b0;
          in_init      <= 1'b0;
          is_clear     <= 1'b0;
          cnt          <= '0;
          phase        <= PH_SETUP;
          state        <= XFER;
        end

        FETCH: begin
          // mem_addr was registered on entry; the RAM answers during LOAD.
          phase <= PH_LOAD;
          state <= XFER;
        end

        XFER: begin
          case (phase)
            PH_LOAD: begin
              bus.LCD_DATA <= bus.mem_data;
              bus.LCD_RS   <= 1'b1;
              is_clear     <= 1'b0;
              cnt          <= '0;
              phase        <= PH_SETUP;
            end
            PH_SETUP: begin
              if (cnt == SETUP_TC) begin
                cnt        <= '0;
                bus.LCD_EN <= 1'b1;
                phase      <= PH_PULSE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PH_PULSE: begin
              if (cnt == EN_TC) begin
                cnt        <= '0;
                bus.LCD_EN <= 1'b0;
                phase      <= PH_WAIT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PH_WAIT: begin
              if (!wait_done) begin
                cnt <= cnt + 1'b1;
              end else begin
                cnt <= '0;
                if (in_init) begin
                  if (init_idx == 2'd3) begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                  end else begin
                    init_idx <= init_idx + 1'b1;
                    state    <= INIT;
                  end
                end else if (!bus.LCD_RS) begin
                  // row command just finished: first character of the row
                  bus.mem_addr <= next_addr;
                  next_addr    <= next_addr + 1'b1;
                  state        <= FETCH;
                end else if (col != LAST_COL) begin
                  col          <= col + 1'b1;
                  bus.mem_addr <= next_addr;
                  next_addr    <= next_addr + 1'b1;
                  state        <= FETCH;
                end else if (row != LAST_ROW) begin
                  col   <= '0;
                  row   <= row + 1'b1;
                  state <= ROW_CMD;
                end else begin
                  bus.frame_done <= 1'b1;
                  bus.mem_addr   <= '0;
                  next_addr      <= '0;
                  state          <= FRAME_END;
                end
              end
            end
            default: phase <= PH_LOAD;
          endcase
        end

        FRAME_END: begin
          bus.frame_done <= 1'b0;
          if (start_frame) begin
            pending <= 1'b0;
            row     <= '0;
            col     <= '0;
            state   <= ROW_CMD;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// Self-checking bench for lcd_frame_refresher (2-row and 1-row builds).
module tb_lcd_frame_refresher;
  localparam int COLS = 4, ROWS = 2, S = 1, E = 2, CMD = 5, CLR = 20, PWR = 10;
  localparam int CMD_P     = 1 + S + E + CMD;
  localparam int CHR_P     = 2 + S + E + CMD;
  localparam int FRAME_LEN = ROWS * CMD_P + ROWS * COLS * CHR_P + 1;
  localparam int INIT_LEN  = PWR + 3 * CMD_P + (1 + S + E + CLR);

  typedef struct {
    logic [7:0] data;
    bit         rs;
    int         rise_off;
    int         width;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_frame_refresher_if #(.AW(3)) bus ();
  lcd_frame_refresher_if #(.AW(2)) bus1 ();

  lcd_frame_refresher #(
    .COLS(COLS), .ROWS(ROWS), .SETUP_CYCLES(S), .EN_CYCLES(E),
    .CMD_DELAY(CMD), .CLR_DELAY(CLR), .PWR_DELAY(PWR)
  ) dut (.clk(clk), .rst(rst), .bus(bus.master));

  lcd_frame_refresher #(
    .COLS(COLS), .ROWS(1), .SETUP_CYCLES(S), .EN_CYCLES(E),
    .CMD_DELAY(CMD), .CLR_DELAY(CLR), .PWR_DELAY(PWR)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  logic [7:0] mem0 [8];
  logic [7:0] mem1 [4];
  always @(posedge clk) bus.mem_data  <= mem0[bus.mem_addr];
  always @(posedge clk) bus1.mem_data <= mem1[bus1.mem_addr];

  int n_err = 0, n_chk = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_data[$];
  bit         m_rs[$];
  int         m_rise[$], m_width[$], m_addr[$], done_q[$];
  logic [7:0] m1_data[$];
  bit         m1_rs[$];
  logic [7:0] e_data[$];
  bit         e_rs[$];
  int         e_rise[$], e_addr[$];
  logic en_q = 1'b0, en1_q = 1'b0;
  int   cur_w = 0;
  int   base_tbl[4] = '{'h00, 'h40, 'h14, 'h54};

  always @(negedge clk) begin
    en_q <= bus.LCD_EN;
    if (bus.LCD_EN && !en_q) begin
      m_data.push_back(bus.LCD_DATA);
      m_rs.push_back(bus.LCD_RS);
      m_rise.push_back(cyc);
      m_addr.push_back(int'(bus.mem_addr));
      cur_w <= 1;
    end else if (bus.LCD_EN) begin
      cur_w <= cur_w + 1;
    end else if (en_q) begin
      m_width.push_back(cur_w);
    end
    if (bus.frame_done) done_q.push_back(cyc);
  end

  always @(negedge clk) begin
    en1_q <= bus1.LCD_EN;
    if (bus1.LCD_EN && !en1_q) begin
      m1_data.push_back(bus1.LCD_DATA);
      m1_rs.push_back(bus1.LCD_RS);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    m_data.delete(); m_rs.delete(); m_rise.delete(); m_width.delete();
    m_addr.delete(); done_q.delete();
    e_data.delete(); e_rs.delete(); e_rise.delete(); e_addr.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " LCD_DATA"}, int'(bus.LCD_DATA), 0);
    chk({tag, " LCD_RS"}, int'(bus.LCD_RS), 0);
    chk({tag, " LCD_RW"}, int'(bus.LCD_RW), 0);
    chk({tag, " LCD_EN"}, int'(bus.LCD_EN), 0);
    chk({tag, " LCD_ON"}, int'(bus.LCD_ON), 0);
    chk({tag, " busy"}, int'(bus.busy), 1);
    chk({tag, " frame_done"}, int'(bus.frame_done), 0);
    chk({tag, " mem_addr"}, int'(bus.mem_addr), 0);
  endtask

  // Reference: byte list and EN-rise cycle of nframes back-to-back frames,
  // first frame's row command loaded in the cycle after edge 'start'.
  task automatic model_frames(input int start, input int nframes);
    int t = start;
    for (int f = 0; f < nframes; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        e_data.push_back(8'(8'h80 | base_tbl[r]));
        e_rs.push_back(1'b0);
        e_rise.push_back(t + 1 + S);
        e_addr.push_back(-1);
        t += CMD_P;
        for (int c = 0; c < COLS; c++) begin
          e_data.push_back(mem0[r * COLS + c]);
          e_rs.push_back(1'b1);
          e_rise.push_back(t + 2 + S);
          e_addr.push_back(r * COLS + c);
          t += CHR_P;
        end
      end
      t += 1;
    end
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, " byte count"}, m_data.size(), e_data.size());
    for (int i = 0; i < e_data.size() && i < m_data.size(); i++) begin
      chk($sformatf("%s byte%0d data", tag, i), int'(m_data[i]), int'(e_data[i]));
      chk($sformatf("%s byte%0d rs", tag, i), int'(m_rs[i]), int'(e_rs[i]));
      chk($sformatf("%s byte%0d rise", tag, i), m_rise[i], e_rise[i]);
      if (e_addr[i] >= 0)
        chk($sformatf("%s byte%0d mem_addr", tag, i), m_addr[i], e_addr[i]);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (bus.busy !== 1'b0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " reached idle"}, int'(bus.busy), 0);
  endtask

  task automatic pulse_req(output int er);
    bus.refresh_req = 1'b1;
    er = cyc + 1;
    @(posedge clk); #1;
    bus.refresh_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t init_tbl[4];
    int   t0, n, er, busy_low;
    init_tbl[0] = '{8'h38, 1'b0, PWR + 1 + S, E};
    init_tbl[1] = '{8'h0C, 1'b0, PWR + 1 + S + CMD_P, E};
    init_tbl[2] = '{8'h01, 1'b0, PWR + 1 + S + 2 * CMD_P, E};
    init_tbl[3] = '{8'h06, 1'b0, PWR + 1 + S + 2 * CMD_P + (E + CLR + 1 + S), E};

    bus.refresh_req = 1'b0; bus.auto_refresh = 1'b0;
    bus1.refresh_req = 1'b0; bus1.auto_refresh = 1'b0;
    for (int i = 0; i < 8; i++) mem0[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem1[i] = 8'($urandom);

    // Reset values and power-on init sequence.
    repeat (3) @(posedge clk); #1;
    check_reset_vals("reset");
    clear_mon(); m1_data.delete(); m1_rs.delete();
    rst = 1'b1; t0 = cyc;
    n = 0;
    while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("init length", n, INIT_LEN);
    chk("LCD_ON after init", int'(bus.LCD_ON), 1);
    chk("init byte count", m_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < m_data.size() && i < m_width.size()) begin
        chk($sformatf("init%0d data", i), int'(m_data[i]), int'(init_tbl[i].data));
        chk($sformatf("init%0d rs", i), int'(m_rs[i]), int'(init_tbl[i].rs));
        chk($sformatf("init%0d rise", i), m_rise[i] - t0, init_tbl[i].rise_off);
        chk($sformatf("init%0d en width", i), m_width[i], init_tbl[i].width);
      end
    end
    chk("rows1 init count", m1_data.size(), 4);
    if (m1_data.size() > 0) chk("rows1 function set", int'(m1_data[0]), 'h30);

    // Single requests with random memory contents.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) mem0[i] = 8'($urandom);
      repeat ($urandom_range(1, 5)) @(posedge clk); #1;
      clear_mon();
      pulse_req(er);
      @(posedge clk); #1;
      chk($sformatf("f%0d row0 cmd latency", k), int'(bus.LCD_DATA), 'h80);
      wait_idle($sformatf("f%0d", k), 300);
      model_frames(er, 1);
      compare_stream($sformatf("f%0d", k));
      chk($sformatf("f%0d done pulses", k), done_q.size(), 1);
      if (done_q.size() > 0)
        chk($sformatf("f%0d done latency", k), done_q[0] - (er - 1), FRAME_LEN);
      chk($sformatf("f%0d mem_addr wrap", k), int'(bus.mem_addr), 0);
    end

    // Three extra requests during a frame collapse into one extra frame.
    clear_mon();
    pulse_req(er);
    for (int j = 0; j < 3; j++) begin
      repeat ($urandom_range(3, 20)) @(posedge clk); #1;
      bus.refresh_req = 1'b1;
      @(posedge clk); #1;
      bus.refresh_req = 1'b0;
    end
    wait_idle("pend", 500);
    model_frames(er, 2);
    compare_stream("pend");
    chk("pend done pulses", done_q.size(), 2);

    // Request coinciding with frame_done.
    clear_mon();
    pulse_req(er);
    n = 0;
    while (!bus.frame_done && n < 300) begin @(negedge clk); n++; end
    bus.refresh_req = 1'b1;
    @(posedge clk); #1;
    bus.refresh_req = 1'b0;
    wait_idle("coinc", 500);
    model_frames(er, 2);
    compare_stream("coinc");
    chk("coinc done pulses", done_q.size(), 2);

    // Auto refresh: back-to-back frames, then drop mid-frame.
    clear_mon();
    bus.auto_refresh = 1'b1;
    er = cyc + 1;
    busy_low = 0; n = 0;
    do begin
      @(posedge clk); #1;
      if (!bus.busy) busy_low++;
      n++;
    end while (done_q.size() < 3 && n < 600);
    chk("auto busy low cycles", busy_low, 0);
    repeat (20) @(posedge clk); #1;
    bus.auto_refresh = 1'b0;
    wait_idle("auto", 300);
    chk("auto done pulses", done_q.size(), 4);
    model_frames(er, 4);
    compare_stream("auto");

    // Reset while EN is high on a character byte.
    clear_mon();
    pulse_req(er);
    n = 0;
    while (!(bus.LCD_EN && bus.LCD_RS) && n < 200) begin @(negedge clk); n++; end
    chk("EN high on char before reset", int'(bus.LCD_EN && bus.LCD_RS), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid reset");
    clear_mon();
    rst = 1'b1; t0 = cyc;
    n = 0;
    while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("re-init length", n, INIT_LEN);
    chk("re-init byte count", m_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < m_data.size()) begin
        chk($sformatf("re-init%0d data", i), int'(m_data[i]), int'(init_tbl[i].data));
        chk($sformatf("re-init%0d rise", i), m_rise[i] - t0, init_tbl[i].rise_off);
      end
    end

    // One-row build: single row command, then the four characters.
    for (int i = 0; i < 4; i++) mem1[i] = 8'($urandom);
    m1_data.delete(); m1_rs.delete();
    bus1.refresh_req = 1'b1;
    @(posedge clk); #1;
    bus1.refresh_req = 1'b0;
    n = 0;
    while (bus1.busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("rows1 reached idle", int'(bus1.busy), 0);
    chk("rows1 byte count", m1_data.size(), 5);
    for (int i = 0; i < 5 && i < m1_data.size(); i++) begin
      chk($sformatf("rows1 byte%0d data", i), int'(m1_data[i]),
          (i == 0) ? 'h80 : int'(mem1[i - 1]));
      chk($sformatf("rows1 byte%0d rs", i), int'(m1_rs[i]), (i == 0) ? 0 : 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
